// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared constants and helper functions for the operand-forwarding unit.
//   SEL_RF     : select code meaning "register-file data"
//   sel_width  : width of a select code for a given number of producer stages
//   stage_sel  : maps producer stage index i to its select code (i+1)
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int SEL_RF = 0;

    // One code per producer stage plus one for the register file.
    function automatic int sel_width(input int nstage);
        return (nstage + 1 > 1) ? $clog2(nstage + 1) : 1;
    endfunction

    function automatic int stage_sel(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Combinational youngest-first priority matcher for one source operand.
// Stage 0 is the youngest producer; the lowest matching index wins and shadows
// any older match. Register x0 never forwards and always reads as zero.
//
// Ports:
//   addr      in   REGW          source register address
//   rf_data   in   XLEN          register-file read data
//   stg_we    in   NSTAGE        per-stage write enable
//   stg_rd    in   NSTAGE*REGW   per-stage destination register (slice i)
//   stg_data  in   NSTAGE*XLEN   per-stage result (slice i)
//   stg_ld    in   NSTAGE        per-stage "load data not yet valid"
//   sel       out  SELW          0 = register file, i+1 = stage i
//   data      out  XLEN          selected operand
//   hazard    out  1             winning producer is a pending load
// -----------------------------------------------------------------------------
module fwd_match
    import fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NSTAGE = 2,
    parameter int REGW   = 5
) (
    input  logic [REGW-1:0]              addr,
    input  logic [XLEN-1:0]              rf_data,
    input  logic [NSTAGE-1:0]            stg_we,
    input  logic [NSTAGE*REGW-1:0]       stg_rd,
    input  logic [NSTAGE*XLEN-1:0]       stg_data,
    input  logic [NSTAGE-1:0]            stg_ld,
    output logic [sel_width(NSTAGE)-1:0] sel,
    output logic [XLEN-1:0]              data,
    output logic                         hazard
);

    localparam int SELW = sel_width(NSTAGE);

    logic found;

    always_comb begin
        // NOTE: every output gets a default before any condition; a path that
        // leaves one unassigned would infer a latch.
        sel    = SELW'(SEL_RF);
        data   = rf_data;
        hazard = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (!found && stg_we[i] && (stg_rd[i*REGW +: REGW] == addr)) begin
                sel    = SELW'(stage_sel(i));
                data   = stg_data[i*XLEN +: XLEN];
                hazard = stg_ld[i];
                found  = 1'b1;
            end
        end
        // x0 is hardwired zero: ignore the register file and every producer.
        if (addr == '0) begin
            sel    = SELW'(SEL_RF);
            data   = '0;
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/fwd_operand_unit.sv
// -----------------------------------------------------------------------------
// fwd_operand_unit
// Operand forwarding and load-use hazard unit between decode and ID/EX.
// Selects each source operand from the register file or the youngest matching
// in-flight producer, requests a stall when that producer is a pending load,
// and registers the operands and select codes into EX.
//
// Optional feature macro: FWD_STATS_EN adds saturating statistics counters
// stat_stall_cyc and stat_fwd_cnt.
//
// Ports:
//   clk, rst             in   clock, synchronous active-high reset
//   rs1_addr, rs2_addr   in   REGW         source register addresses
//   rf_rs1, rf_rs2       in   XLEN         register-file read data
//   stg_we               in   NSTAGE       per-stage write enable
//   stg_rd               in   NSTAGE*REGW  per-stage destination register
//   stg_data             in   NSTAGE*XLEN  per-stage result
//   stg_ld               in   NSTAGE       per-stage pending-load flag
//   adv                  in   1            ID/EX register enable
//   flush                in   1            squash EX (insert bubble)
//   stall                out  1            combinational load-use stall
//   op1, op2             out  XLEN         registered operands
//   fwd_sel1, fwd_sel2   out  SELW         registered select codes
//   ex_valid             out  1            EX holds a real instruction
//   stat_stall_cyc       out  32           (FWD_STATS_EN) stalled advance cycles
//   stat_fwd_cnt         out  32           (FWD_STATS_EN) forwarded operands
// -----------------------------------------------------------------------------
module fwd_operand_unit
    import fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NSTAGE = 2,
    parameter int REGW   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REGW-1:0]              rs1_addr,
    input  logic [REGW-1:0]              rs2_addr,
    input  logic [XLEN-1:0]              rf_rs1,
    input  logic [XLEN-1:0]              rf_rs2,
    input  logic [NSTAGE-1:0]            stg_we,
    input  logic [NSTAGE*REGW-1:0]       stg_rd,
    input  logic [NSTAGE*XLEN-1:0]       stg_data,
    input  logic [NSTAGE-1:0]            stg_ld,
    input  logic                         adv,
    input  logic                         flush,
    output logic                         stall,
    output logic [XLEN-1:0]              op1,
    output logic [XLEN-1:0]              op2,
    output logic [sel_width(NSTAGE)-1:0] fwd_sel1,
    output logic [sel_width(NSTAGE)-1:0] fwd_sel2,
    output logic                         ex_valid
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                  stat_stall_cyc,
    output logic [31:0]                  stat_fwd_cnt
`endif
);

    localparam int SELW = sel_width(NSTAGE);

    logic [SELW-1:0] sel1, sel2;
    logic [XLEN-1:0] data1, data2;
    logic            hazard1, hazard2;

    fwd_match #(.XLEN(XLEN), .NSTAGE(NSTAGE), .REGW(REGW)) u_match1 (
        .addr     (rs1_addr),
        .rf_data  (rf_rs1),
        .stg_we   (stg_we),
        .stg_rd   (stg_rd),
        .stg_data (stg_data),
        .stg_ld   (stg_ld),
        .sel      (sel1),
        .data     (data1),
        .hazard   (hazard1)
    );

    fwd_match #(.XLEN(XLEN), .NSTAGE(NSTAGE), .REGW(REGW)) u_match2 (
        .addr     (rs2_addr),
        .rf_data  (rf_rs2),
        .stg_we   (stg_we),
        .stg_rd   (stg_rd),
        .stg_data (stg_data),
        .stg_ld   (stg_ld),
        .sel      (sel2),
        .data     (data2),
        .hazard   (hazard2)
    );

    // A flushed or resetting instruction never needs to wait for a load.
    assign stall = (hazard1 | hazard2) & ~flush & ~rst;

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (rst || flush) begin
            op1      <= '0;
            op2      <= '0;
            fwd_sel1 <= SELW'(SEL_RF);
            fwd_sel2 <= SELW'(SEL_RF);
            ex_valid <= 1'b0;
        end else if (adv) begin
            if (stall) begin
                // Bubble into EX; decode keeps its instruction.
                op1      <= '0;
                op2      <= '0;
                fwd_sel1 <= SELW'(SEL_RF);
                fwd_sel2 <= SELW'(SEL_RF);
                ex_valid <= 1'b0;
            end else begin
                op1      <= data1;
                op2      <= data2;
                fwd_sel1 <= sel1;
                fwd_sel2 <= sel2;
                ex_valid <= 1'b1;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic        capture;
    logic [1:0]  fwd_inc;
    logic [32:0] fwd_sum;

    assign capture = adv & ~stall & ~flush;
    assign fwd_inc = {1'b0, sel1 != SELW'(SEL_RF)} + {1'b0, sel2 != SELW'(SEL_RF)};
    assign fwd_sum = {1'b0, stat_fwd_cnt} + {31'b0, fwd_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cyc <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            if (stall && adv && (stat_stall_cyc != '1))
                stat_stall_cyc <= stat_stall_cyc + 32'd1;
            // Carry out of the 33-bit sum means the count would wrap.
            if (capture)
                stat_fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fwd_operand_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_operand_unit
// Self-checking bench for fwd_operand_unit. A reference model computes the
// expected stall and next register contents each cycle; expected register
// contents are queued when stimulus is applied and popped after the edge.
// -----------------------------------------------------------------------------
module tb_fwd_operand_unit;

    localparam int XLEN   = 32;
    localparam int NSTAGE = 2;
    localparam int REGW   = 5;
    localparam int SELW   = 2;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [SELW-1:0] s1;
        logic [SELW-1:0] s2;
        logic            v;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [REGW-1:0]        rs1_addr, rs2_addr;
    logic [XLEN-1:0]        rf_rs1, rf_rs2;
    logic [NSTAGE-1:0]      stg_we;
    logic [NSTAGE*REGW-1:0] stg_rd;
    logic [NSTAGE*XLEN-1:0] stg_data;
    logic [NSTAGE-1:0]      stg_ld;
    logic                   adv, flush;
    logic                   stall;
    logic [XLEN-1:0]        op1, op2;
    logic [SELW-1:0]        fwd_sel1, fwd_sel2;
    logic                   ex_valid;
`ifdef FWD_STATS_EN
    logic [31:0]            stat_stall_cyc, stat_fwd_cnt;
    logic [31:0]            exp_stall_cyc, exp_fwd_cnt;
`endif

    exp_t sbq[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_operand_unit #(.XLEN(XLEN), .NSTAGE(NSTAGE), .REGW(REGW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rf_rs1   (rf_rs1),
        .rf_rs2   (rf_rs2),
        .stg_we   (stg_we),
        .stg_rd   (stg_rd),
        .stg_data (stg_data),
        .stg_ld   (stg_ld),
        .adv      (adv),
        .flush    (flush),
        .stall    (stall),
        .op1      (op1),
        .op2      (op2),
        .fwd_sel1 (fwd_sel1),
        .fwd_sel2 (fwd_sel2),
        .ex_valid (ex_valid)
`ifdef FWD_STATS_EN
        ,
        .stat_stall_cyc (stat_stall_cyc),
        .stat_fwd_cnt   (stat_fwd_cnt)
`endif
    );

    // Reference matcher: walk from oldest to youngest so the youngest match
    // overwrites older ones.
    function automatic void model_match(input logic [REGW-1:0] a, input logic [XLEN-1:0] rf,
                                        output logic [XLEN-1:0] d, output logic [SELW-1:0] s,
                                        output logic h);
        d = rf;
        s = '0;
        h = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (stg_we[i] && stg_rd[i*REGW +: REGW] == a) begin
                d = stg_data[i*XLEN +: XLEN];
                s = SELW'(i + 1);
                h = stg_ld[i];
            end
        end
        if (a == '0) begin
            d = '0;
            s = '0;
            h = 1'b0;
        end
    endfunction

    task automatic set_stage(input int i, input logic we, input logic [REGW-1:0] rd,
                             input logic [XLEN-1:0] data, input logic ld);
        stg_we[i]                 = we;
        stg_rd[i*REGW +: REGW]    = rd;
        stg_data[i*XLEN +: XLEN]  = data;
        stg_ld[i]                 = ld;
    endtask

    // Inputs are already driven (1 time unit after a rising edge). Check the
    // combinational stall, queue the expected registers, cross the edge and
    // compare what the DUT captured.
    task automatic step(input string name);
        logic [XLEN-1:0] d1, d2;
        logic [SELW-1:0] s1, s2;
        logic            h1, h2, exp_stall;
        exp_t            nxt, e;
        #1;
        model_match(rs1_addr, rf_rs1, d1, s1, h1);
        model_match(rs2_addr, rf_rs2, d2, s2, h2);
        exp_stall = (h1 | h2) & ~flush & ~rst;
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL %s stall: got %b expected %b", name, stall, exp_stall);
        end
        if (rst || flush) nxt = '0;
        else if (adv) begin
            if (exp_stall) nxt = '0;
            else begin
                nxt.op1 = d1; nxt.op2 = d2; nxt.s1 = s1; nxt.s2 = s2; nxt.v = 1'b1;
            end
        end else nxt = cur;
        cur = nxt;
        sbq.push_back(nxt);
`ifdef FWD_STATS_EN
        if (rst) begin
            exp_stall_cyc = 0;
            exp_fwd_cnt   = 0;
        end else begin
            if (exp_stall && adv) exp_stall_cyc++;
            if (adv && !exp_stall && !flush)
                exp_fwd_cnt += 32'(s1 != 0) + 32'(s2 != 0);
        end
`endif
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checks++;
        if (op1 !== e.op1) begin
            errors++; $display("FAIL %s op1: got %h expected %h", name, op1, e.op1);
        end
        checks++;
        if (op2 !== e.op2) begin
            errors++; $display("FAIL %s op2: got %h expected %h", name, op2, e.op2);
        end
        checks++;
        if (fwd_sel1 !== e.s1) begin
            errors++; $display("FAIL %s fwd_sel1: got %0d expected %0d", name, fwd_sel1, e.s1);
        end
        checks++;
        if (fwd_sel2 !== e.s2) begin
            errors++; $display("FAIL %s fwd_sel2: got %0d expected %0d", name, fwd_sel2, e.s2);
        end
        checks++;
        if (ex_valid !== e.v) begin
            errors++; $display("FAIL %s ex_valid: got %b expected %b", name, ex_valid, e.v);
        end
`ifdef FWD_STATS_EN
        checks++;
        if (stat_stall_cyc !== exp_stall_cyc) begin
            errors++; $display("FAIL %s stat_stall_cyc: got %0d expected %0d", name, stat_stall_cyc, exp_stall_cyc);
        end
        checks++;
        if (stat_fwd_cnt !== exp_fwd_cnt) begin
            errors++; $display("FAIL %s stat_fwd_cnt: got %0d expected %0d", name, stat_fwd_cnt, exp_fwd_cnt);
        end
`endif
    endtask

    task automatic idle_inputs();
        rs1_addr = '0; rs2_addr = '0; rf_rs1 = '0; rf_rs2 = '0;
        stg_we = '0; stg_rd = '0; stg_data = '0; stg_ld = '0;
        adv = 1'b1; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        // A hazard present during reset must not raise stall.
        set_stage(0, 1'b1, 5'd3, 32'h1234, 1'b1);
        rs1_addr = 5'd3;
        step("reset_a");
        step("reset_b");
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_no_match();
        idle_inputs();
        rs1_addr = 5'd5; rs2_addr = 5'd6; rf_rs1 = 32'h11; rf_rs2 = 32'h22;
        step("no_match");
        checks++;
        if (op1 !== 32'h11 || fwd_sel1 !== 2'd0 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL no_match_direct: got op1=%h sel1=%0d v=%b expected op1=11 sel1=0 v=1",
                     op1, fwd_sel1, ex_valid);
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        rs1_addr = 5'd5; rs2_addr = 5'd9; rf_rs1 = 32'h55; rf_rs2 = 32'h99;
        set_stage(0, 1'b1, 5'd5, 32'hAAAA, 1'b0);
        set_stage(1, 1'b1, 5'd5, 32'hBBBB, 1'b0);
        step("priority_young");
        checks++;
        if (op1 !== 32'hAAAA || fwd_sel1 !== 2'd1) begin
            errors++;
            $display("FAIL priority_young_direct: got op1=%h sel1=%0d expected op1=aaaa sel1=1", op1, fwd_sel1);
        end
        stg_we[0] = 1'b0;
        step("priority_old");
        checks++;
        if (op1 !== 32'hBBBB || fwd_sel1 !== 2'd2) begin
            errors++;
            $display("FAIL priority_old_direct: got op1=%h sel1=%0d expected op1=bbbb sel1=2", op1, fwd_sel1);
        end
        // rs2 forwarded from the oldest stage.
        rs2_addr = 5'd5; rs1_addr = 5'd7;
        step("priority_rs2");
    endtask

    task automatic test_x0();
        idle_inputs();
        rs1_addr = 5'd0; rf_rs1 = 32'h7;
        rs2_addr = 5'd0; rf_rs2 = 32'h8;
        set_stage(0, 1'b1, 5'd0, 32'hDEAD, 1'b1);
        step("x0_guard");
        checks++;
        if (op1 !== 32'h0 || fwd_sel1 !== 2'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_direct: got op1=%h sel1=%0d expected op1=0 sel1=0", op1, fwd_sel1);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        rs1_addr = 5'd1; rf_rs1 = 32'h100; rs2_addr = 5'd3; rf_rs2 = 32'h300;
        set_stage(0, 1'b1, 5'd3, 32'hFFFF, 1'b1);
        step("load_stall_1");
        step("load_stall_2");
        stg_ld[0] = 1'b0;
        stg_data[XLEN-1:0] = 32'h42;
        step("load_done");
        checks++;
        if (op2 !== 32'h42 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_done_direct: got op2=%h v=%b expected op2=42 v=1", op2, ex_valid);
        end
        // Older load shadowed by a younger non-load writer of the same register.
        set_stage(0, 1'b1, 5'd3, 32'h77, 1'b0);
        set_stage(1, 1'b1, 5'd3, 32'h66, 1'b1);
        step("load_shadowed");
        // Same load now visible through rs1 only when stage0 stops writing.
        stg_we[0] = 1'b0;
        rs1_addr = 5'd3; rs2_addr = 5'd2;
        step("load_old_rs1");
    endtask

    task automatic test_flush();
        idle_inputs();
        rs1_addr = 5'd4;
        set_stage(0, 1'b1, 5'd4, 32'h44, 1'b1);
        flush = 1'b1;
        step("flush_hazard");
        flush = 1'b0;
        stg_ld = '0;
        step("flush_after");
        flush = 1'b1; adv = 1'b0;
        step("flush_no_adv");
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        rs2_addr = 5'd8;
        set_stage(1, 1'b1, 5'd8, 32'h88, 1'b1);
        step("mid_stall");
        rst = 1'b1;
        step("mid_stall_rst");
        rst = 1'b0;
        stg_ld = '0;
        step("mid_stall_after");
    endtask

    task automatic test_hold();
        idle_inputs();
        rs1_addr = 5'd10; rf_rs1 = 32'hCAFE; rs2_addr = 5'd11;
        set_stage(1, 1'b1, 5'd11, 32'hBEEF, 1'b0);
        step("hold_load");
        adv = 1'b0;
        rf_rs1 = 32'h1; stg_data = '1; rs2_addr = 5'd12;
        step("hold_1");
        set_stage(0, 1'b1, 5'd10, 32'h5, 1'b1);
        step("hold_2_hazard");
        checks++;
        if (op1 !== 32'hCAFE || op2 !== 32'hBEEF || fwd_sel2 !== 2'd2) begin
            errors++;
            $display("FAIL hold_direct: got op1=%h op2=%h sel2=%0d expected cafe beef 2", op1, op2, fwd_sel2);
        end
    endtask

    task automatic test_same_stage();
        idle_inputs();
        rs1_addr = 5'd4; rs2_addr = 5'd4;
        set_stage(1, 1'b1, 5'd4, 32'h4444_0000, 1'b0);
        step("same_stage");
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 60; n++) begin
            rst      = ($urandom_range(0, 19) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            adv      = ($urandom_range(0, 3) != 0);
            rs1_addr = REGW'($urandom_range(0, 4));
            rs2_addr = REGW'($urandom_range(0, 4));
            rf_rs1   = $urandom;
            rf_rs2   = $urandom;
            for (int i = 0; i < NSTAGE; i++)
                set_stage(i, 1'($urandom), REGW'($urandom_range(0, 4)), $urandom,
                          ($urandom_range(0, 3) == 0));
            step("random");
        end
        rst = 1'b0;
        idle_inputs();
    endtask

`ifdef FWD_STATS_EN
    task automatic test_stats();
        idle_inputs();
        rst = 1'b1;
        step("stats_rst");
        rst = 1'b0;
        rs1_addr = 5'd6;
        set_stage(0, 1'b1, 5'd6, 32'h6, 1'b1);
        repeat (3) step("stats_stall");
        checks++;
        if (stat_stall_cyc !== 32'd3) begin
            errors++; $display("FAIL stats_stall_direct: got %0d expected 3", stat_stall_cyc);
        end
        stg_ld = '0;
        rs2_addr = 5'd6;
        step("stats_fwd");
        checks++;
        if (stat_fwd_cnt !== 32'd2) begin
            errors++; $display("FAIL stats_fwd_direct: got %0d expected 2", stat_fwd_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = '0;
`ifdef FWD_STATS_EN
        exp_stall_cyc = 0;
        exp_fwd_cnt   = 0;
`endif
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_no_match();
        test_priority();
        test_x0();
        test_load_use();
        test_flush();
        test_reset_mid_stall();
        test_hold();
        test_same_stage();
        test_random();
`ifdef FWD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
